avmm_burst_responder: RTL and testbench
=======================================

# avmm_burst_responder

Avalon-MM slave-side responder for the packet client's CSR and scratch space. It terminates the slave end of the AVMM link produced by the AXI-Lite-to-AVMM bridge. It backs a small flop-based word array with burst read and write support, per-byte write masking, and per-transaction write responses. Out-of-range addresses return SLVERR.

## Interface
- ADDR_WIDTH, 32, byte address width; must match the connected avmm_if.
- DATA_WIDTH, 64, data width; a multiple of 8. DATA_N_BYTES = DATA_WIDTH/8.
- BURSTCOUNT_WIDTH, 7, burstcount width.
- DEPTH_WORDS, 16, number of storage words; a power of 2, at least 2.
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- avmm  avmm_if.slave  –  slave modport. Signal directions:
  - Outputs: waitrequest, readdata[DATA_WIDTH], readdatavalid, response[2], writeresponsevalid.
  - Inputs: address, burstcount, writedata, byteenable, write, read.

## Operation
- Word index = address >> log2(DATA_N_BYTES). Low byte-offset bits are ignored.
- In range: word index < DEPTH_WORDS.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- burstcount 0 is treated as 1.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE, command acceptance:
  - A command is accepted when read or write is high and waitrequest is low.
  - If write and read are both high, the write is accepted and the read is discarded (illegal master behaviour).
- Write beat (IDLE with write, or WR_BURST with write):
  - Bytes with byteenable=1 update the word at the current beat address. Other bytes are unchanged.
  - An out-of-range beat writes nothing and sets the burst error flag.
- Write burst of N beats:
  - First beat latches N and the start address.
  - Beat k targets start + k words. The address input on beats after the first is ignored.
  - If N > 1, go to WR_BURST with remaining = N−1. Cycles with write=0 are idle and do not advance the burst.
  - Once the last beat is accepted, return to IDLE.
- Read in IDLE:
  - Latch N and the start word. Register beat 0.
  - If N > 1, go to RD_BURST with remaining = N−1. Each RD_BURST cycle registers the next beat. Return to IDLE when remaining reaches 0.
  - read and write are ignored while in RD_BURST.
- Read beat data:
  - readdata = stored word for an in-range beat, with response OKAY.
  - readdata = 0 for an out-of-range beat, with response SLVERR.
  - Byteenable is ignored on reads.
  - Each beat carries its own response.
- Address arithmetic:
  - Beat address = start word + beat index, computed modulo 2^(ADDR_WIDTH − log2(DATA_N_BYTES)).
  - Each beat is range-checked independently, so a burst crossing DEPTH_WORDS gives OKAY beats followed by SLVERR beats.
- Write response:
  - writeresponsevalid is a one-cycle pulse, once per write burst, in the cycle after the last beat is accepted.
  - response on that pulse is SLVERR if any beat in the burst was out of range, otherwise OKAY.
- response is only meaningful when readdatavalid or writeresponsevalid is high. It is 0 otherwise.

## Timing
- waitrequest = rst OR (state == RD_BURST). Combinational from the state register and rst.
- Read accepted at cycle T with N beats:
  - readdatavalid high for cycles T+1 … T+N, consecutive, no gaps.
  - waitrequest high for T+1 … T+N−1, low at T+N. A new command can be accepted in T+N.
  - Single reads (N = 1) sustain one read per cycle.
- Write accepted at cycle T: storage is updated at the T clock edge. A read accepted at T+1 returns the new data.
- Last write beat at cycle T: writeresponsevalid at T+1. A new command in T+1 is accepted normally.
  - If a read is accepted at T+1, its data (T+2) and the write response (T+1) never coincide.
- Reset value of every output while rst = 1 and in the cycle it is sampled:
  - waitrequest = 1; readdatavalid, writeresponsevalid, readdata, response = 0.
  - All storage words = 0. State = IDLE.
- Reset during a burst:
  - The burst is abandoned. No further readdatavalid beats or writeresponsevalid pulse from it.
  - Bytes already written are cleared by the reset.
- The cycle after rst deasserts: waitrequest = 0, commands are accepted.

## Test plan
- Single write then read: write addr 0x08, data 0x1122334455667788, byteenable 0xFF, burstcount 1. Then read addr 0x08 at the next cycle.
  - Required: writeresponsevalid with OKAY one cycle after the write.
  - Required: readdatavalid with 0x1122334455667788 and OKAY one cycle after the read.
- Byte masking: write 0xFFFF_FFFF_FFFF_FFFF to word 3, then write 0 with byteenable 0x0F.
  - Required: read of word 3 returns 0xFFFFFFFF00000000.
- Read burst: write words 0–3 with values 0xA0–0xA3, then read addr 0, burstcount 4.
  - Required: 4 consecutive readdatavalid beats 0xA0–0xA3.
  - Required: waitrequest high exactly 3 cycles.
- Boundary burst: read word 14, burstcount 4 (DEPTH_WORDS = 16).
  - Required: beats 1–2 OKAY with data, beats 3–4 SLVERR with data 0.
- Write burst crossing the end: write burst of 3 starting at word 15, with an idle cycle between beats 1 and 2.
  - Required: word 15 is written; one writeresponsevalid with SLVERR, one cycle after the third beat.
- Reset mid read burst: assert rst for 1 cycle during beat 2 of an 8-beat read.
  - Required: no further readdatavalid.
  - Required: waitrequest = 1 in the reset cycle and 0 the next cycle.
  - Required: all words read back 0.

Source files
------------

// File: rtl/avmm_burst_responder_if.sv
// Avalon-MM link between a master and the burst responder.
// Slave modport: responder drives waitrequest and the read/write response side.
interface avmm_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]       address;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [DATA_WIDTH/8-1:0]     byteenable;
    logic                        write;
    logic                        read;
    logic                        waitrequest;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        readdatavalid;
    logic [1:0]                  response;
    logic                        writeresponsevalid;

    modport slave (
        input  address, burstcount, writedata, byteenable, write, read,
        output waitrequest, readdata, readdatavalid, response,
        output writeresponsevalid
    );

    modport master (
        output address, burstcount, writedata, byteenable, write, read,
        input  waitrequest, readdata, readdatavalid, response,
        input  writeresponsevalid
    );
endinterface

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst responder backed by a flop word array.
// Per-beat range checks; one write response per write burst.
module avmm_burst_responder #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int DEPTH_WORDS      = 16
) (
    input logic   clk,
    input logic   rst,
    avmm_if.slave avmm
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int WW   = ADDR_WIDTH - OFFW;
    localparam int IW   = $clog2(DEPTH_WORDS);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0]       mem [DEPTH_WORDS];
    logic [WW-1:0]               cur_word;
    logic [WW-1:0]               beat_word;
    logic [BURSTCOUNT_WIDTH-1:0] remaining;
    logic [BURSTCOUNT_WIDTH-1:0] remaining_nx;
    logic [BURSTCOUNT_WIDTH-1:0] bc;
    logic                        err;
    logic                        err_nx;
    logic                        in_range;
    logic                        wr_beat;
    logic                        rd_beat;
    logic                        last_wr;
    logic [IW-1:0]               idx;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdv_q;
    logic                  wrv_q;
    logic [1:0]            rsp_q;

    assign avmm.waitrequest        = rst | (state == RD_BURST);
    assign avmm.readdata           = rst ? '0 : rdata_q;
    assign avmm.readdatavalid      = rdv_q & ~rst;
    assign avmm.writeresponsevalid = wrv_q & ~rst;
    assign avmm.response           = rst ? 2'b00 : rsp_q;

    always_comb begin
        state_nx     = state;
        wr_beat      = 1'b0;
        rd_beat      = 1'b0;
        beat_word    = cur_word;
        remaining_nx = remaining;
        bc           = (avmm.burstcount == '0)
                     ? BURSTCOUNT_WIDTH'(1) : avmm.burstcount;
        unique case (state)
            IDLE: begin
                beat_word    = avmm.address[ADDR_WIDTH-1:OFFW];
                remaining_nx = bc - BURSTCOUNT_WIDTH'(1);
                // Write wins when a master raises both strobes.
                if (avmm.write) begin
                    wr_beat = 1'b1;
                    if (bc != BURSTCOUNT_WIDTH'(1)) state_nx = WR_BURST;
                end else if (avmm.read) begin
                    rd_beat = 1'b1;
                    if (bc != BURSTCOUNT_WIDTH'(1)) state_nx = RD_BURST;
                end
            end
            WR_BURST: begin
                if (avmm.write) begin
                    wr_beat      = 1'b1;
                    remaining_nx = remaining - BURSTCOUNT_WIDTH'(1);
                    if (remaining == BURSTCOUNT_WIDTH'(1)) state_nx = IDLE;
                end
            end
            RD_BURST: begin
                rd_beat      = 1'b1;
                remaining_nx = remaining - BURSTCOUNT_WIDTH'(1);
                if (remaining == BURSTCOUNT_WIDTH'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        in_range = beat_word < WW'(DEPTH_WORDS);
        idx      = beat_word[IW-1:0];
        last_wr  = wr_beat && (remaining_nx == '0);
        err_nx   = ((state == IDLE) ? 1'b0 : err) | (wr_beat & ~in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
            cur_word  <= '0;
            remaining <= '0;
            err       <= 1'b0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            wrv_q     <= 1'b0;
            rsp_q     <= OKAY;
        end else begin
            remaining <= remaining_nx;
            err       <= err_nx;
            rdv_q     <= rd_beat;
            wrv_q     <= last_wr;
            if (wr_beat || rd_beat) cur_word <= beat_word + WW'(1);
            if (wr_beat && in_range) begin
                for (int b = 0; b < NB; b++) begin
                    if (avmm.byteenable[b])
                        mem[idx][8*b +: 8] <= avmm.writedata[8*b +: 8];
                end
            end
            rdata_q <= (rd_beat && in_range) ? mem[idx] : '0;
            if ((rd_beat && !in_range) || (last_wr && err_nx))
                rsp_q <= SLVERR;
            else
                rsp_q <= OKAY;
        end
    end
endmodule

// File: tb/tb_avmm_burst_responder.sv
// Bench for avmm_burst_responder: vector table, directed bursts,
// reset mid-burst and random bursts against a word-array model.
module tb_avmm_burst_responder;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int BW    = 7;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avmm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW)) bus ();

    avmm_burst_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURSTCOUNT_WIDTH(BW), .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .avmm(bus)
    );

    int applied     = 0;
    int miscompares = 0;
    logic [63:0] model [DEPTH];

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [6:0]  bc;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.burstcount = 7'd1;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        chk("rst_waitreq", 64'(bus.waitrequest), 64'd1);
        chk("rst_rdv", 64'(bus.readdatavalid), 64'd0);
        chk("rst_wrv", 64'(bus.writeresponsevalid), 64'd0);
        chk("rst_rdata", bus.readdata, 64'd0);
        chk("rst_resp", 64'(bus.response), 64'd0);
        tick();
        rst = 1'b0;
        clear_model();
        #1;
        chk("post_rst_waitreq", 64'(bus.waitrequest), 64'd0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [6:0] bc,
                            input logic [63:0] d0, input logic [63:0] dstep,
                            input logic [7:0] be, input int gap,
                            input bit rnd);
        int          n;
        logic [28:0] start;
        logic [28:0] w;
        logic [63:0] d;
        logic [7:0]  b;
        bit          err;
        n     = (bc == 0) ? 1 : int'(bc);
        start = addr[31:3];
        err   = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0 && k == gap) begin
                idle_inputs();
                bus.address = $urandom;
                tick();
                chk("wr_gap_wrv", 64'(bus.writeresponsevalid), 64'd0);
            end
            d = rnd ? {$urandom, $urandom} : d0 + dstep * 64'(k);
            b = rnd ? 8'($urandom) : be;
            bus.write      = 1'b1;
            bus.read       = (k == 0 && rnd) ? 1'($urandom) : 1'b0;
            bus.address    = (k == 0) ? addr : $urandom;
            bus.burstcount = (k == 0) ? bc : 7'($urandom);
            bus.writedata  = d;
            bus.byteenable = b;
            w = start + 29'(k);
            if (w < 29'(DEPTH)) begin
                for (int j = 0; j < 8; j++)
                    if (b[j]) model[w[3:0]][8*j +: 8] = d[8*j +: 8];
            end else begin
                err = 1'b1;
            end
            tick();
            if (k < n - 1)
                chk("wr_mid_wrv", 64'(bus.writeresponsevalid), 64'd0);
        end
        idle_inputs();
        chk("wr_wrv", 64'(bus.writeresponsevalid), 64'd1);
        chk("wr_resp", 64'(bus.response), err ? 64'd2 : 64'd0);
        chk("wr_rdv", 64'(bus.readdatavalid), 64'd0);
        tick();
        chk("wr_pulse_once", 64'(bus.writeresponsevalid), 64'd0);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [6:0] bc);
        int          n;
        int          wcnt;
        logic [28:0] start;
        logic [28:0] w;
        n     = (bc == 0) ? 1 : int'(bc);
        start = addr[31:3];
        wcnt  = 0;
        bus.write      = 1'b0;
        bus.read       = 1'b1;
        bus.address    = addr;
        bus.burstcount = bc;
        bus.byteenable = 8'($urandom);
        tick();
        for (int k = 1; k <= n; k++) begin
            w = start + 29'(k - 1);
            chk("rd_rdv", 64'(bus.readdatavalid), 64'd1);
            chk("rd_wrv", 64'(bus.writeresponsevalid), 64'd0);
            if (w < 29'(DEPTH)) begin
                chk("rd_data", bus.readdata, model[w[3:0]]);
                chk("rd_resp", 64'(bus.response), 64'd0);
            end else begin
                chk("rd_oor_data", bus.readdata, 64'd0);
                chk("rd_oor_resp", 64'(bus.response), 64'd2);
            end
            chk("rd_waitreq", 64'(bus.waitrequest), (k < n) ? 64'd1 : 64'd0);
            if (bus.waitrequest) wcnt++;
            if (k < n) begin
                // Commands raised mid-burst must be ignored.
                bus.write      = 1'($urandom);
                bus.read       = 1'($urandom);
                bus.address    = $urandom;
                bus.writedata  = {$urandom, $urandom};
                bus.byteenable = 8'($urandom);
                bus.burstcount = 7'($urandom);
            end else begin
                idle_inputs();
            end
            tick();
        end
        chk("rd_wait_count", 64'(wcnt), 64'(n - 1));
        chk("rd_after_rdv", 64'(bus.readdatavalid), 64'd0);
    endtask

    initial begin
        int          cnt;
        logic [28:0] word;
        idle_inputs();
        clear_model();
        do_reset();

        tbl.push_back('{0, 32'h08, 7'd1, 64'h1122334455667788, 8'hFF, 64'd0, 2'b00});
        tbl.push_back('{1, 32'h08, 7'd1, 64'd0, 8'h00, 64'h1122334455667788, 2'b00});
        tbl.push_back('{0, 32'h18, 7'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'd0, 2'b00});
        tbl.push_back('{0, 32'h18, 7'd1, 64'd0, 8'h0F, 64'd0, 2'b00});
        tbl.push_back('{1, 32'h18, 7'd1, 64'd0, 8'h00, 64'hFFFFFFFF00000000, 2'b00});
        tbl.push_back('{1, 32'h1D, 7'd1, 64'd0, 8'hFF, 64'hFFFFFFFF00000000, 2'b00});
        tbl.push_back('{0, 32'h80, 7'd1, 64'h1234, 8'hFF, 64'd0, 2'b10});
        tbl.push_back('{1, 32'h80, 7'd1, 64'd0, 8'h00, 64'd0, 2'b10});
        tbl.push_back('{1, 32'h78, 7'd1, 64'd0, 8'h00, 64'd0, 2'b00});
        tbl.push_back('{2, 32'h78, 7'd1, 64'hDEAD, 8'hFF, 64'd0, 2'b00});
        tbl.push_back('{1, 32'h78, 7'd1, 64'd0, 8'h00, 64'hDEAD, 2'b00});
        tbl.push_back('{0, 32'h10, 7'd1, 64'h5555, 8'h00, 64'd0, 2'b00});
        tbl.push_back('{1, 32'h10, 7'd1, 64'd0, 8'h00, 64'd0, 2'b00});
        tbl.push_back('{0, 32'h20, 7'd0, 64'hCAFE, 8'hFF, 64'd0, 2'b00});
        tbl.push_back('{1, 32'h20, 7'd0, 64'd0, 8'h00, 64'hCAFE, 2'b00});

        foreach (tbl[i]) begin
            bus.write      = (tbl[i].op != 1);
            bus.read       = (tbl[i].op != 0);
            bus.address    = tbl[i].addr;
            bus.burstcount = tbl[i].bc;
            bus.writedata  = tbl[i].data;
            bus.byteenable = tbl[i].be;
            tick();
            chk("tbl_wrv", 64'(bus.writeresponsevalid), 64'(tbl[i].op != 1));
            chk("tbl_rdv", 64'(bus.readdatavalid), 64'(tbl[i].op == 1));
            chk("tbl_resp", 64'(bus.response), 64'(tbl[i].exp_resp));
            if (tbl[i].op == 1)
                chk("tbl_rdata", bus.readdata, tbl[i].exp_data);
        end
        idle_inputs();
        tick();

        do_reset();

        wr_burst(32'h0, 7'd4, 64'hA0, 64'd1, 8'hFF, -1, 1'b0);
        rd_burst(32'h0, 7'd4);

        wr_burst(32'd14 * 8, 7'd2, 64'hE0, 64'd1, 8'hFF, -1, 1'b0);
        rd_burst(32'd14 * 8, 7'd4);

        wr_burst(32'd15 * 8, 7'd3, 64'hF00D, 64'd1, 8'hFF, 1, 1'b0);
        rd_burst(32'd15 * 8, 7'd1);

        rd_burst(32'hFFFF_FFF8, 7'd3);

        wr_burst(32'h0, 7'd8, 64'h100, 64'd1, 8'hFF, -1, 1'b0);
        bus.read       = 1'b1;
        bus.address    = 32'h0;
        bus.burstcount = 7'd8;
        tick();
        chk("mid_rst_beat0", bus.readdata, 64'h100);
        idle_inputs();
        tick();
        chk("mid_rst_beat1", bus.readdata, 64'h101);
        chk("mid_rst_rdv1", 64'(bus.readdatavalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_waitreq_hi", 64'(bus.waitrequest), 64'd1);
        chk("mid_rst_rdv_gated", 64'(bus.readdatavalid), 64'd0);
        tick();
        rst = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_waitreq_lo", 64'(bus.waitrequest), 64'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.readdatavalid || bus.writeresponsevalid) cnt++;
            tick();
        end
        chk("mid_rst_no_beats", 64'(cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) rd_burst(32'(i * 8), 7'd1);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) == 0)
                word = 29'h1FFF_FFFF - 29'($urandom_range(0, 3));
            else
                word = 29'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1)
                wr_burst({word, 3'($urandom)}, 7'($urandom_range(0, 5)),
                         64'd0, 64'd0, 8'h00, $urandom_range(0, 4), 1'b1);
            else
                rd_burst({word, 3'($urandom)}, 7'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
